uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with a built-in bit-rate divider, an input FIFO and a valid/ready write port. It replaces the fixed 8-bit, fixed-parity, word-parallel transmitter with a true bit-serial line driver. Data width, divider width and FIFO depth are set at elaboration. Parity mode, stop-bit count and bit period are run-time inputs. It sits between the SoC write path and the TX pad; the companion receiver shares the same configuration inputs.

## Interface
Parameters:
- DATA_W, 8, data bits per frame (legal 5..9).
- DIV_W, 16, width of the bit-period divisor.
- FIFO_DEPTH, 4, input FIFO entries (power of two, at least 2).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- divisor  in  DIV_W  bit period = divisor+1 clk cycles; divisor 0 is treated as 1.
- parity_mode  in  2  00 none, 01 odd, 10 even, 11 none.
- stop2  in  1  0 = one stop bit, 1 = two stop bits.
- tx_data  in  DATA_W  word to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  FIFO can accept a word (fifo_count != FIFO_DEPTH).
- tx  out  1  serial line, idle high, registered.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently held in the FIFO.

## Operation
- A word is accepted on a rising clk edge where tx_valid && tx_ready. The write pointer and count update on that edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE:** if the FIFO is non-empty at an edge, pop the head into the shift register and latch divisor, parity_mode and stop2. Drive tx=0 and enter START.
- **START:** tx=0 for one bit period, then go to DATA with tx driven by bit 0.
- **DATA:** send DATA_W bits LSB first, one bit period each. After the last bit, go to PARITY if the latched mode is 01/10, otherwise go to STOP.
- **PARITY:** odd sends ~^word and even sends ^word (computed on the latched word). Lasts one bit period.
- **STOP:** tx=1 for 1 or 2 bit periods, per the latched stop2.
- **End of the final stop period:**
  - If the FIFO is non-empty, pop, latch the configuration and drive the next start bit on the same edge. There is no idle gap.
  - Otherwise go to IDLE with tx=1.
- **Bit counter:** counts 0..divisor and is cleared at every frame start. A bit boundary occurs when counter == latched divisor.
- **Configuration changes:** changes to divisor, parity_mode or stop2 mid-frame have no effect until the next pop.
- **Full FIFO:** tx_ready=0, and a push attempt is ignored (no overwrite, no error flag).
- **Simultaneous push and pop:** count is unchanged and both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- **Reset (asynchronous assert, synchronous-safe release):**
  - tx=1, busy=0, fifo_count=0, tx_ready=1 while reset is low and after release.
  - FSM goes to IDLE and the FIFO is emptied.
  - A frame in flight is abandoned and tx returns high immediately.
- **Latency:** word accepted at edge E0, then tx falls at edge E1 when the FSM is IDLE.
- **Frame length:** (1 + DATA_W + P + S) × (divisor+1) cycles, with P∈{0,1} and S∈{1,2}.
- tx_ready is combinational from the registered fifo_count only; it has no path from tx_valid.
- busy falls on the edge where the FSM enters IDLE with the FIFO empty.
- **Capacity:** with continuous pushes from idle, FIFO_DEPTH+1 words are accepted before tx_ready first deasserts (one word goes to the shifter).

## Test plan
- **Single frame, odd parity:** DATA_W=8, divisor=3, parity_mode=01, stop2=0, push 0x55.
  - tx sequence per 4-cycle bit: 0,1,0,1,0,1,0,1,0,1,1 (parity 1).
  - Frame is 44 cycles; busy drops after the frame.
- **Even parity, 2 stops:** parity_mode=10, stop2=1, push 0x07.
  - Bits: start 0, data 1,1,1,0,0,0,0,0, parity 1, stops 1,1.
  - Frame is 12 bit periods.
- **Back-to-back with fill:** push 0xA0..0xA5 in 6 consecutive cycles, holding valid.
  - Exactly 5 words are accepted; tx_ready is low while fifo_count=4.
  - The 5 frames are contiguous with no idle cycles between stop and start.
  - The 6th word is accepted only when a pop frees an entry.
- **Configuration change mid-frame:** change divisor 3→7 and parity 01→00 during the data bits of frame 1.
  - Frame 1 keeps 4-cycle bits with parity.
  - Frame 2 uses 8-cycle bits and no parity.
- **Reset mid-frame:** assert reset low during data bit 3.
  - tx=1, fifo_count=0, busy=0, tx_ready=1 immediately.
  - After release, no residual frame is sent; a new push of 0x3C transmits correctly.
- **divisor=0:** behaves identically to divisor=1 (2-cycle bits).

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO, a valid/ready write port and a per-frame
// latched configuration (divisor, parity mode, stop-bit count).
module uart_tx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIV_W-1:0]              divisor,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned BitW = $clog2(DATA_W);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              push, pop;
  logic [DATA_W-1:0] head;

  // Frame state
  state_e            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              stop_idx_q, stop_idx_d;
  logic              tx_q, tx_d;
  logic              boundary;
  logic              start_frame;

  assign tx_ready   = (count_q != CntW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign tx         = tx_q;
  assign busy       = (state_q != StIdle) || (count_q != '0);
  assign boundary   = (cnt_q == div_q);

  // FIFO data write; storage needs no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Frame state register; tx idles high and returns high at once on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      div_q      <= DIV_W'(1);
      bit_q      <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
    end
  end

  // Next-state: bit timing, frame sequencing and pop/latch at frame start.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    stop2_d     = stop2_q;
    stop_idx_d  = stop_idx_q;
    tx_d        = tx_q;
    pop         = 1'b0;
    start_frame = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = boundary ? '0 : cnt_q + DIV_W'(1);
    end

    case (state_q)
      StIdle: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (count_q != '0) start_frame = 1'b1;
      end
      StStart: begin
        if (boundary) begin
          state_d = StData;
          tx_d    = shift_q[0];
          bit_d   = '0;
        end
      end
      StData: begin
        if (boundary) begin
          if (bit_q == BitW'(DATA_W - 1)) begin
            if (par_en_q) begin
              state_d = StParity;
              tx_d    = par_bit_q;
            end else begin
              state_d    = StStop;
              tx_d       = 1'b1;
              stop_idx_d = 1'b0;
            end
          end else begin
            bit_d   = bit_q + BitW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      StParity: begin
        if (boundary) begin
          state_d    = StStop;
          tx_d       = 1'b1;
          stop_idx_d = 1'b0;
        end
      end
      StStop: begin
        if (boundary) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else if (count_q != '0) begin
            // Back-to-back: next start bit begins on this same edge.
            start_frame = 1'b1;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    if (start_frame) begin
      pop       = 1'b1;
      state_d   = StStart;
      tx_d      = 1'b0;
      cnt_d     = '0;
      shift_d   = head;
      div_d     = (divisor == '0) ? DIV_W'(1) : divisor;
      par_en_d  = parity_mode[0] ^ parity_mode[1];
      par_bit_d = (parity_mode == 2'b01) ? ~^head : ^head;
      stop2_d   = stop2;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frames are checked cycle by cycle on the
// falling clock edge against hand-built bit vectors (index 0 = start bit).
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] divisor;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_fifo #(.DATA_W(8), .DIV_W(16), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .divisor     (divisor),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx          (tx),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // No parity, one stop: {stop, data, start}.
  function automatic logic [15:0] frm8(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  // Called just after a negedge; the word is offered for exactly one posedge.
  task automatic push(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Wait up to max_wait negedges for the start bit, then check every cycle.
  task automatic expect_frame(input string tag, input logic [15:0] bits, input int nbits,
                              input int period, input int max_wait);
    int found = 0;
    for (int w = 0; w < max_wait; w++) begin
      @(negedge clk);
      if (tx == 1'b0) begin
        found = 1;
        break;
      end
    end
    check_eq({tag, "_start"}, found, 1);
    if (found == 0) return;
    for (int c = 1; c < nbits * period; c++) begin
      @(negedge clk);
      check_eq($sformatf("%s_bit%0d_cyc%0d", tag, c / period, c), tx, bits[c / period]);
    end
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_tx"}, tx, 1'b1);
  endtask

  initial begin
    int acc;
    int low_seen;
    int got_ready;

    reset       = 1'b0;
    divisor     = 16'd3;
    parity_mode = 2'b01;
    stop2       = 1'b0;
    tx_data     = '0;
    tx_valid    = 1'b0;

    // Reset state, during and after reset
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_count", fifo_count, 3'd0);
    check_eq("rst_ready", tx_ready, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rel_tx", tx, 1'b1);
    check_eq("rel_ready", tx_ready, 1'b1);

    // Single frame, odd parity: 0x55 -> 0,1,0,1,0,1,0,1,0,1(par),1
    push(8'h55);
    check_eq("t1_busy", busy, 1'b1);
    check_eq("t1_count", fifo_count, 3'd1);
    expect_frame("t1", 16'h06AA, 11, 4, 1);
    expect_idle("t1_end");

    // Even parity, two stops: 0x07 -> 0,1,1,1,0,0,0,0,0,1(par),1,1
    parity_mode = 2'b10;
    stop2       = 1'b1;
    push(8'h07);
    expect_frame("t2", 16'h0E0E, 12, 4, 1);
    expect_idle("t2_end");

    // Back-to-back fill: 5 accepted, 6th waits for a pop; frames contiguous
    parity_mode = 2'b00;
    stop2       = 1'b0;
    fork
      begin
        acc = 0;
        tx_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
          tx_data = 8'hA0 + 8'(acc);
          if (k == 5) begin
            check_eq("t3_full_count", fifo_count, 3'd4);
            check_eq("t3_full_ready", tx_ready, 1'b0);
          end
          if (tx_ready) acc++;
          @(negedge clk);
        end
        check_eq("t3_accepted", acc, 5);
        got_ready = 0;
        for (int w = 0; w < 200; w++) begin
          if (tx_ready) begin
            got_ready = 1;
            break;
          end
          @(negedge clk);
        end
        check_eq("t3_sixth_ready", got_ready, 1);
        check_eq("t3_sixth_count", fifo_count, 3'd3);
        @(negedge clk);
        tx_valid = 1'b0;
      end
      begin
        expect_frame("t3_a0", frm8(8'hA0), 10, 4, 4);
        expect_frame("t3_a1", frm8(8'hA1), 10, 4, 1);
        expect_frame("t3_a2", frm8(8'hA2), 10, 4, 1);
        expect_frame("t3_a3", frm8(8'hA3), 10, 4, 1);
        expect_frame("t3_a4", frm8(8'hA4), 10, 4, 1);
        expect_frame("t3_a5", frm8(8'hA5), 10, 4, 1);
        expect_idle("t3_end");
      end
    join

    // Config change mid-frame: 0x81 odd parity at 4-cycle bits, then 0x5A at 8, no parity
    divisor     = 16'd3;
    parity_mode = 2'b01;
    fork
      begin
        push(8'h81);
        push(8'h5A);
        repeat (12) @(negedge clk);
        divisor     = 16'd7;
        parity_mode = 2'b00;
      end
      begin
        expect_frame("t4_f1", 16'h0702, 11, 4, 4);
        expect_frame("t4_f2", frm8(8'h5A), 10, 8, 1);
        expect_idle("t4_end");
      end
    join

    // Reset during data bit 3 of 0x12 with 0x34 queued
    divisor     = 16'd3;
    parity_mode = 2'b00;
    push(8'h12);
    push(8'h34);
    repeat (17) @(negedge clk);
    check_eq("t5_pre_tx", tx, 1'b0);
    check_eq("t5_pre_count", fifo_count, 3'd1);
    reset = 1'b0;
    #1;
    check_eq("t5_rst_tx", tx, 1'b1);
    check_eq("t5_rst_count", fifo_count, 3'd0);
    check_eq("t5_rst_busy", busy, 1'b0);
    check_eq("t5_rst_ready", tx_ready, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    low_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tx == 1'b0) low_seen = 1;
    end
    check_eq("t5_no_residual", low_seen, 0);
    check_eq("t5_post_busy", busy, 1'b0);
    push(8'h3C);
    expect_frame("t5_3c", frm8(8'h3C), 10, 4, 1);
    expect_idle("t5_end");

    // divisor 0 and divisor 1 both give 2-cycle bits
    divisor = 16'd0;
    push(8'h96);
    expect_frame("t6_div0", frm8(8'h96), 10, 2, 1);
    expect_idle("t6_div0_end");
    divisor = 16'd1;
    push(8'h96);
    expect_frame("t6_div1", frm8(8'h96), 10, 2, 1);
    expect_idle("t6_div1_end");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
